// File: rtl/swerv_types_pkg.sv
// Shared EXU/IFU types: predictor lookup and training packets.
// BTB index width is the single source for both packet layouts.
package swerv_types_pkg;

  localparam int BTB_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [BTB_IDX_W-1:0] idx;
    logic                 way;
    logic [1:0]           hist;
  } predict_pkt_t;

  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic                 way;
    logic [1:0]           hist;
    logic                 ataken;
    logic                 misp;
  } bp_upd_pkt_t;

endpackage

// File: rtl/exu_bp_upd_fifo.sv
// Two-write/one-read predictor update FIFO.
// Pushes beyond free space are refused, youngest first.
module exu_bp_upd_fifo
  import swerv_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [1:0]  push_req,
  input  bp_upd_pkt_t push0,
  input  bp_upd_pkt_t push1,
  input  logic        pop,
  output logic        head_valid,
  output bp_upd_pkt_t head,
  output logic [1:0]  push_acc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr1;
  logic [CW-1:0] count;
  logic [CW-1:0] space;
  bp_upd_pkt_t   mem [DEPTH];

  // a same-cycle pop frees its slot for this cycle's pushes
  assign space = CW'(DEPTH) - count + CW'(pop);
  assign wptr1 = wptr + PW'(1);

  always_comb begin
    push_acc = push_req;
    if (CW'(push_req) > space) begin
      push_acc = space[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_acc != 2'd0) begin
        mem[wptr] <= push0;
      end
      if (push_acc == 2'd2) begin
        mem[wptr1] <= push1;
      end
      wptr  <= wptr + PW'(push_acc);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push_acc) - CW'(pop);
    end
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rptr] : '0;

endmodule

// File: rtl/exu_bp_resolve_ctl.sv
// Upper-pipe branch resolution: flush arbitration to the IFU and
// buffering of predictor training updates.
module exu_bp_resolve_ctl
  import swerv_types_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BTB_IDX_W
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        freeze,
  input  logic        flush_lower,
  input  logic        i0_valid,
  input  logic        i1_valid,
  input  logic        i0_flush_upper,
  input  logic        i1_flush_upper,
  input  logic [31:1] i0_flush_path,
  input  logic [31:1] i1_flush_path,
  input  bp_upd_pkt_t i0_upd,
  input  bp_upd_pkt_t i1_upd,
  output logic        exu_flush_upper,
  output logic [31:1] exu_flush_path,
  output logic        upd_valid,
  output bp_upd_pkt_t upd_pkt,
  input  logic        upd_ready,
  output logic [7:0]  upd_drop_cnt
);

  if (IDX_W != BTB_IDX_W) begin : g_idx_chk
    $error("IDX_W must match BTB_IDX_W");
  end

  logic        i0_q;
  logic        i1_q;
  logic        i0_fl;
  logic        i1_fl;
  logic        flush_d;
  logic [31:1] path_d;
  logic        flush_r;
  logic [1:0]  push_req;
  logic [1:0]  push_acc;
  logic [1:0]  drop;
  logic [8:0]  drop_sum;
  logic        pop;
  bp_upd_pkt_t push0;

  assign i0_q  = i0_valid & ~flush_lower & ~freeze;
  assign i0_fl = i0_q & i0_flush_upper;
  // an older-lane flush squashes the younger lane entirely
  assign i1_q  = i1_valid & ~flush_lower & ~freeze & ~i0_fl;
  assign i1_fl = i1_q & i1_flush_upper;

  always_comb begin
    flush_d = 1'b0;
    path_d  = exu_flush_path;
    unique case (1'b1)
      i0_fl: begin
        flush_d = 1'b1;
        path_d  = i0_flush_path;
      end
      i1_fl: begin
        flush_d = 1'b1;
        path_d  = i1_flush_path;
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      flush_r        <= 1'b0;
      exu_flush_path <= '0;
    end else begin
      flush_r        <= flush_d;
      exu_flush_path <= path_d;
    end
  end

  assign exu_flush_upper = flush_r & ~freeze;

  assign push_req = {1'b0, i0_q} + {1'b0, i1_q};
  assign push0    = i0_q ? i0_upd : i1_upd;
  assign pop      = upd_valid & upd_ready & ~freeze;

  exu_bp_upd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push_req  (push_req),
    .push0     (push0),
    .push1     (i1_upd),
    .pop       (pop),
    .head_valid(upd_valid),
    .head      (upd_pkt),
    .push_acc  (push_acc)
  );

  assign drop     = push_req - push_acc;
  assign drop_sum = {1'b0, upd_drop_cnt} + 9'(drop);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      upd_drop_cnt <= '0;
    end else begin
      upd_drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

endmodule
